// File: rtl/spi_shift_engine_pkg.sv
// spi_shift_engine_pkg: shift-register mode encoding shared by the SPI datapath
package spi_shift_engine_pkg;
  typedef enum logic [1:0] {
    SR_HOLD  = 2'b00,
    SR_SHIFT = 2'b01,
    SR_CLEAR = 2'b10,
    SR_PLOAD = 2'b11
  } sr_mode_e;
endpackage

// File: rtl/spi_shift_engine_sclk_edge_detect.sv
// sclk_edge_detect: two-flop synchroniser plus history flop giving one-cycle SCLK edge strobes
module sclk_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic serial_clk,
  output logic rise,
  output logic fall,
  output logic level
);
  logic s1, s2, s3;
  always_ff @(posedge clk)
    if (!reset_n) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {serial_clk, s1, s2};
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
  assign level = s2;
endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI mode 0-3 shift datapath with bit counter, received-word latch and frame-done pulse
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_clk,
  input  logic [1:0]       mode,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsb_first,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic [WIDTH-1:0] rx_data,
  output logic             frame_done,
  output logic [CNT_W-1:0] bit_count
);
  logic [WIDTH-1:0] memory, shifted;
  logic rise, fall, level, edge_any, lead, sample, launch, last;
  sr_mode_e op;
  sclk_edge_detect u_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .serial_clk(serial_clk),
    .rise      (rise),
    .fall      (fall),
    .level     (level)
  );
  // a leading edge is the one that leaves the idle level cpol
  always_comb begin
    edge_any = rise | fall;
    lead     = edge_any & (level ^ cpol);
    sample   = cpha ? edge_any & ~lead : lead;
    launch   = cpha ? lead : edge_any & ~lead;
    last     = bit_count == CNT_W'(WIDTH - 1);
    op       = sr_mode_e'(mode);
    shifted  = lsb_first ? {serial_in, memory[WIDTH-1:1]} : {memory[WIDTH-2:0], serial_in};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      memory     <= '0;
      rx_data    <= '0;
      bit_count  <= '0;
      serial_out <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (op == SR_CLEAR) begin
        memory     <= '0;
        bit_count  <= '0;
        serial_out <= 1'b0;
      end else if (op == SR_PLOAD) begin
        memory     <= parallel_in;
        bit_count  <= '0;
        serial_out <= lsb_first ? parallel_in[0] : parallel_in[WIDTH-1];
      end else if (op == SR_SHIFT && sample) begin
        memory    <= shifted;
        bit_count <= last ? '0 : bit_count + 1'b1;
        if (last) begin
          rx_data    <= shifted;
          frame_done <= 1'b1;
        end
      end else if (op == SR_SHIFT && launch)
        serial_out <= lsb_first ? memory[0] : memory[WIDTH-1];
    end
  end
  assign parallel_out = memory;
endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Parametrised successor to the 8-bit SPI shift register; it is the datapath of the SPI master and slave ports.
- Runs entirely in the `clk` domain. The raw `serial_clk` pin is synchronised and edge-detected, so there is no sensitivity to the pin itself.
- Adds SPI mode 0–3 sampling/launch edge selection (CPOL/CPHA), MSB/LSB-first order, a per-frame bit counter, a received-word latch and a frame-done pulse.

Parameters:
- WIDTH, 8, shift register and frame length in bits (>=2)
- CNT_W, $clog2(WIDTH), bit counter width (derived; do not override)

Ports:
- clk  in  1  system clock; all state updates on posedge clk
- reset_n  in  1  synchronous, active-low reset, sampled on posedge clk
- serial_clk  in  1  raw SPI SCLK, asynchronous to clk
- mode  in  2  00 HOLD, 01 SHIFT, 10 CLEAR, 11 PLOAD
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- lsb_first  in  1  0: shift left, MSB out first; 1: shift right, LSB out first
- parallel_in  in  WIDTH  word to load in PLOAD
- serial_in  in  1  MOSI/MISO receive bit
- parallel_out  out  WIDTH  current shift register contents
- serial_out  out  1  transmit bit (registered)
- rx_data  out  WIDTH  last completed received frame
- frame_done  out  1  one-cycle pulse when WIDTH bits have been sampled
- bit_count  out  CNT_W  bits sampled in the current frame

Behaviour:
- Reset (reset_n=0 at posedge clk): memory, rx_data, bit_count, serial_out, frame_done and the sync/edge flops all go to 0. Reset has priority over everything, including mid-frame activity.
- Synchroniser: serial_clk passes through 2 flops (s1, s2), plus a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An edge is seen 3 clk cycles after the pin transition.
  - At most one edge per cycle.
  - Requirement: SCLK high and low times must each be >= 3 clk periods.
- Edge roles: leading edge = rise if cpol=0, else fall.
  - sample_edge = leading if cpha=0, else trailing.
  - launch_edge = the other edge.
- Mode priority within one cycle: PLOAD/CLEAR take effect and any concurrent SCLK edge is discarded.
- HOLD: memory, bit_count and serial_out are frozen; edges are ignored. A frame resumes where it paused when SHIFT returns.
- CLEAR: memory <= 0, bit_count <= 0, serial_out <= 0; rx_data is unchanged.
- PLOAD:
  - memory <= parallel_in and bit_count <= 0.
  - serial_out <= parallel_in[WIDTH-1] if lsb_first=0, else parallel_in[0]. The first bit is therefore valid before the first sample edge (cpha=0).
- SHIFT on sample_edge:
  - lsb_first=0: memory <= {memory[WIDTH-2:0], serial_in}.
  - lsb_first=1: memory <= {serial_in, memory[WIDTH-1:1]}.
  - bit_count increments.
  - If bit_count was WIDTH-1: bit_count wraps to 0, rx_data <= the new memory value (including the bit just sampled), and frame_done=1 in the following cycle only.
- SHIFT on launch_edge:
  - serial_out <= memory[WIDTH-1] (lsb_first=0) or memory[0] (lsb_first=1).
  - With cpha=0 the first launch edge follows the first sample, so it presents bit 1.
  - With cpha=1 the first launch edge presents bit 0 again; this is harmless and intended.
- Back-to-back frames: the counter wraps without a gap. A new PLOAD between frames is the caller's job.
- frame_done is never asserted by PLOAD, CLEAR or HOLD.
- parallel_out = memory, combinational from the register; serial_out and rx_data are registered.
- Changing cpol/cpha/lsb_first mid-frame is undefined. The bench holds them stable between PLOADs.

Decomposition:
- Shared mode include (extends the existing shift-register modes file): SR_HOLD=2'b00, SR_SHIFT=2'b01, SR_CLEAR=2'b10, SR_PLOAD=2'b11.
- Sub-module sclk_edge_detect: clk, reset_n, serial_clk in; rise, fall, level out. It is reused by the chip-select logic.

Test Plan:
- Reset: hold reset_n=0 mid-shift with memory=0xA5 -> next cycle all outputs 0, bit_count=0, frame_done=0.
- Mode 0, MSB-first:
  - PLOAD 0xC3, then 8 SCLK pulses with serial_in = bits of 0x5A MSB-first.
  - serial_out sequence 1,1,0,0,0,0,1,1.
  - frame_done pulses once, 1 cycle after the 8th rise.
  - rx_data=0x5A, parallel_out=0x5A.
- Mode 3 (cpol=1, cpha=1), LSB-first:
  - PLOAD 0x81, idle SCLK high, receive 0x3C LSB-first.
  - Sampling on rising (trailing) edges; serial_out presents 1,0,0,0,0,0,0,1.
  - rx_data=0x3C.
- HOLD mid-frame: after 3 samples assert HOLD and toggle SCLK 4 times -> bit_count stays 3, memory unchanged. Return to SHIFT and give 5 more samples -> single frame_done.
- Collision: PLOAD 0xFF in the same cycle a sample edge is detected -> memory=0xFF, bit_count=0, no shift.
- WIDTH=16 instance: two back-to-back frames 0x1234 and 0xBEEF -> two frame_done pulses 16 samples apart, rx_data updates correctly; SCLK half-period of 3 clk still works.
